regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_ctrl.sv | 64 ++++++
 rtl/regfile_mp.sv | 83 ++++++++
 tb/tb_regfile_mp.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file and its
// background clear controller.
package regfile_pkg;

    localparam int DEFAULT_XLEN     = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_NUM_READ = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Background sweep controller: walks clear_index from 1 to NUM_REGS-1, one
// register per clock, while busy is high. Register 0 is never targeted.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clear_we,
    output logic [AW-1:0] clear_index
);

    localparam logic [AW-1:0] FIRST_INDEX = AW'(1);
    localparam logic [AW-1:0] LAST_INDEX  = AW'(NUM_REGS - 1);

    clear_state_t  state;
    clear_state_t  state_next;
    logic [AW-1:0] index_next;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of block order.
        if (reset) begin
            state       <= CLEAR;
            clear_index <= FIRST_INDEX;
        end else begin
            state       <= state_next;
            clear_index <= index_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // variable unassigned and no latch is inferred.
        state_next = state;
        index_next = clear_index;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    index_next = FIRST_INDEX;
                end
            end
            CLEAR: begin
                // The last increment wraps to 0; IDLE holds it there unused.
                index_next = clear_index + 1'b1;
                if (clear_index == LAST_INDEX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clear_we = busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NUM_READ combinational read ports,
// hardwired-zero register 0, optional write-to-read forwarding, sweep clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = DEFAULT_XLEN,
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    parameter  int NUM_READ = DEFAULT_NUM_READ,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_req,
    input  logic                           write_enable,
    input  logic [AW-1:0]                  write_address,
    input  logic [XLEN-1:0]                write_data,
    input  logic [NUM_READ-1:0][AW-1:0]    read_address,
    output logic [NUM_READ-1:0][XLEN-1:0]  read_data,
    output logic                           busy
);

    logic            clear_we;
    logic [AW-1:0]   clear_index;
    logic            host_we;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] regs [NUM_REGS];

    regfile_clear_ctrl #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_clear_ctrl (
        .clk         (clk),
        .reset       (reset),
        .clear_req   (clear_req),
        .busy        (busy),
        .clear_we    (clear_we),
        .clear_index (clear_index)
    );

    // A host write only commits from IDLE and loses to a same-cycle clear
    // request or reset; it is also the only write that may be forwarded.
    assign host_we = write_enable && !busy && !clear_req && !reset
                     && (write_address != '0);

    // Single physical write port shared by the sweep and the host.
    assign wr_en   = clear_we || host_we;
    assign wr_addr = clear_we ? clear_index : write_address;
    assign wr_data = clear_we ? '0 : write_data;

    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; zeroing is done
        // by the sweep so the array maps onto plain RAM.
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_read
            logic [AW-1:0]   addr;
            logic            fwd_hit;
            logic [XLEN-1:0] value;

            assign addr    = read_address[p];
            assign fwd_hit = (BYPASS != 0) && host_we && (write_address == addr);

            always_comb begin
                value = regs[addr];
                if (busy || reset || (addr == '0)) begin
                    value = '0;
                end else if (fwd_hit) begin
                    value = write_data;
                end
            end

            assign read_data[p] = value;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default bypass and no-bypass instances
// plus a 4-port/16-entry/64-bit instance, each against an array-based model.
module tb_regfile_mp;

    localparam int AW  = 5;
    localparam int AWW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 clear_req;
    logic                 write_enable;
    logic [AW-1:0]        write_address;
    logic [31:0]          write_data;
    logic [1:0][AW-1:0]   read_address;
    logic [1:0][31:0]     rd_bp;
    logic [1:0][31:0]     rd_nb;
    logic                 busy_bp;
    logic                 busy_nb;

    logic                 clear_req_w;
    logic                 write_enable_w;
    logic [AWW-1:0]       write_address_w;
    logic [63:0]          write_data_w;
    logic [3:0][AWW-1:0]  read_address_w;
    logic [3:0][63:0]     rd_w;
    logic                 busy_w;

    regfile_mp #(.BYPASS(1)) dut_bp (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .read_address(read_address),
        .read_data(rd_bp), .busy(busy_bp)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .read_address(read_address),
        .read_data(rd_nb), .busy(busy_nb)
    );

    regfile_mp #(.XLEN(64), .NUM_REGS(16), .NUM_READ(4), .BYPASS(1)) dut_w (
        .clk(clk), .reset(reset), .clear_req(clear_req_w),
        .write_enable(write_enable_w), .write_address(write_address_w),
        .write_data(write_data_w), .read_address(read_address_w),
        .read_data(rd_w), .busy(busy_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents plus remaining sweep cycles.
    logic [31:0] mem   [32];
    logic [63:0] mem_w [16];
    int sweep_left   = 0;
    int sweep_left_w = 0;

    function automatic logic [31:0] exp_rd(input bit bypass, input logic [AW-1:0] a);
        if (reset || sweep_left > 0 || a == '0) return 32'h0;
        if (bypass && write_enable && !clear_req && write_address == a) return write_data;
        return mem[a];
    endfunction

    function automatic logic [63:0] exp_rd_w(input logic [AWW-1:0] a);
        if (reset || sweep_left_w > 0 || a == '0) return 64'h0;
        if (write_enable_w && !clear_req_w && write_address_w == a) return write_data_w;
        return mem_w[a];
    endfunction

    // Advance one clock, applying the architectural rules to the model.
    task automatic tick();
        if (reset) begin
            sweep_left = 31;
            foreach (mem[i]) mem[i] = '0;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (clear_req) begin
            sweep_left = 31;
            foreach (mem[i]) mem[i] = '0;
        end else if (write_enable && write_address != '0) begin
            mem[write_address] = write_data;
        end
        if (reset) begin
            sweep_left_w = 15;
            foreach (mem_w[i]) mem_w[i] = '0;
        end else if (sweep_left_w > 0) begin
            sweep_left_w--;
        end else if (clear_req_w) begin
            sweep_left_w = 15;
            foreach (mem_w[i]) mem_w[i] = '0;
        end else if (write_enable_w && write_address_w != '0) begin
            mem_w[write_address_w] = write_data_w;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        int cnt_w;
        reset = 1'b1; clear_req = 1'b0; write_enable = 1'b1;
        write_address = 5'd3; write_data = 32'hFFFF_FFFF;
        read_address[0] = 5'd3; read_address[1] = 5'd7;
        clear_req_w = 1'b0; write_enable_w = 1'b0; write_address_w = '0;
        write_data_w = '0;
        for (int p = 0; p < 4; p++) read_address_w[p] = AWW'(p + 1);
        #1;
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (rd_bp[p] !== 32'h0 || rd_nb[p] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read_during_reset port %0d: got %h/%h expected 0", p, rd_bp[p], rd_nb[p]);
            end
        end
        tick();
        n_checks++;
        if (busy_bp !== 1'b1 || busy_nb !== 1'b1 || busy_w !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_held: got %b%b%b expected 111", busy_bp, busy_nb, busy_w);
        end
        reset = 1'b0;
        tick();
        write_enable = 1'b0;
        cnt = 0;
        cnt_w = 0;
        for (int i = 0; i < 100 && (busy_bp || busy_w); i++) begin
            if (busy_bp) cnt++;
            if (busy_w) cnt_w++;
            #1;
            for (int p = 0; p < 2; p++) begin
                if (busy_bp && rd_bp[p] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_read_while_busy port %0d: got %h expected 0", p, rd_bp[p]);
                end
            end
            tick();
        end
        // One further busy cycle was counted before the loop.
        cnt++;
        cnt_w++;
        n_checks++;
        if (cnt != 31) begin
            n_fail++;
            $display("FAIL reset_sweep_len: got %0d expected 31", cnt);
        end
        n_checks++;
        if (cnt_w != 15) begin
            n_fail++;
            $display("FAIL reset_sweep_len_wide: got %0d expected 15", cnt_w);
        end
        for (int a = 0; a < 32; a++) begin
            read_address[0] = AW'(a);
            read_address[1] = AW'(31 - a);
            read_address_w[a % 4] = AWW'(a % 16);
            #1;
            n_checks++;
            if (rd_bp !== '0 || rd_nb !== '0 || rd_w[a % 4] !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_all_zero x%0d: got %h %h %h expected 0", a, rd_bp, rd_nb, rd_w[a % 4]);
            end
        end
    endtask

    task automatic test_bypass();
        write_enable = 1'b1; write_address = 5'd5; write_data = 32'hDEAD_BEEF;
        read_address[0] = 5'd5; read_address[1] = 5'd6;
        #1;
        n_checks++;
        if (rd_bp[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_bp[0]);
        end
        n_checks++;
        if (rd_nb[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL nobypass_same_cycle: got %h expected 0", rd_nb[0]);
        end
        n_checks++;
        if (rd_bp[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h expected 0", rd_bp[1]);
        end
        tick();
        write_enable = 1'b0;
        read_address[1] = 5'd5;
        #1;
        n_checks++;
        if (rd_nb[0] !== 32'hDEAD_BEEF || rd_nb[1] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL nobypass_next_cycle: got %h %h expected deadbeef", rd_nb[0], rd_nb[1]);
        end
        n_checks++;
        if (rd_bp[0] !== 32'hDEAD_BEEF || rd_bp[1] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_stored: got %h %h expected deadbeef", rd_bp[0], rd_bp[1]);
        end
    endtask

    task automatic test_x0();
        write_enable = 1'b1; write_address = 5'd0; write_data = 32'h1234_5678;
        read_address[0] = 5'd0; read_address[1] = 5'd0;
        #1;
        n_checks++;
        if (rd_bp !== '0 || rd_nb !== '0) begin
            n_fail++;
            $display("FAIL x0_no_forward: got %h %h expected 0", rd_bp, rd_nb);
        end
        tick();
        write_enable = 1'b0;
        #1;
        n_checks++;
        if (rd_bp !== '0 || rd_nb !== '0) begin
            n_fail++;
            $display("FAIL x0_after_write: got %h %h expected 0", rd_bp, rd_nb);
        end
    endtask

    task automatic test_clear_sweep();
        int cnt;
        for (int i = 1; i < 32; i++) begin
            write_enable = 1'b1; write_address = AW'(i); write_data = 32'(i * 32'h11);
            tick();
        end
        write_enable = 1'b0;
        for (int i = 1; i < 32; i++) begin
            read_address[0] = AW'(i);
            read_address[1] = AW'(32 - i);
            #1;
            n_checks++;
            if (rd_bp[0] !== 32'(i * 32'h11) || rd_nb[1] !== 32'((32 - i) * 32'h11)) begin
                n_fail++;
                $display("FAIL fill_readback x%0d: got %h %h expected %h %h", i, rd_bp[0], rd_nb[1],
                         32'(i * 32'h11), 32'((32 - i) * 32'h11));
            end
        end
        clear_req = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 100 && busy_bp; i++) begin
            cnt++;
            clear_req = ($urandom_range(0, 3) == 0);
            write_enable = 1'b1;
            write_address = AW'($urandom);
            write_data = $urandom;
            read_address[0] = write_address;
            read_address[1] = AW'($urandom);
            #1;
            if (rd_bp !== '0 || rd_nb !== '0 || busy_nb !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_read_zero cycle %0d: got %h %h busy %b expected 0 0 1", i, rd_bp, rd_nb, busy_nb);
            end
            tick();
        end
        clear_req = 1'b0;
        write_enable = 1'b0;
        n_checks++;
        if (cnt != 31) begin
            n_fail++;
            $display("FAIL clear_sweep_len: got %0d expected 31", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            read_address[0] = AW'(a);
            read_address[1] = AW'(a);
            #1;
            n_checks++;
            if (rd_bp !== '0 || rd_nb !== '0) begin
                n_fail++;
                $display("FAIL after_clear x%0d: got %h %h expected 0", a, rd_bp, rd_nb);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy_bp !== 1'b1 || rd_bp !== '0) begin
            n_fail++;
            $display("FAIL midsweep_reset_busy: got %b %h expected 1 0", busy_bp, rd_bp);
        end
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && busy_bp; i++) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 31) begin
            n_fail++;
            $display("FAIL midsweep_restart_len: got %0d expected 31", cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            clear_req = ($urandom_range(0, 79) == 0);
            write_enable = $urandom_range(0, 1);
            write_address = AW'($urandom);
            write_data = $urandom;
            read_address[0] = ($urandom_range(0, 2) == 0) ? write_address : AW'($urandom);
            read_address[1] = ($urandom_range(0, 2) == 0) ? write_address : AW'($urandom);
            #1;
            for (int p = 0; p < 2; p++) begin
                n_checks++;
                if (rd_bp[p] !== exp_rd(1'b1, read_address[p])) begin
                    n_fail++;
                    $display("FAIL random_bp cycle %0d port %0d: got %h expected %h", i, p, rd_bp[p],
                             exp_rd(1'b1, read_address[p]));
                end
                n_checks++;
                if (rd_nb[p] !== exp_rd(1'b0, read_address[p])) begin
                    n_fail++;
                    $display("FAIL random_nb cycle %0d port %0d: got %h expected %h", i, p, rd_nb[p],
                             exp_rd(1'b0, read_address[p]));
                end
            end
            n_checks++;
            if (busy_bp !== (sweep_left > 0) || busy_nb !== (sweep_left > 0)) begin
                n_fail++;
                $display("FAIL random_busy cycle %0d: got %b %b expected %b", i, busy_bp, busy_nb, sweep_left > 0);
            end
            tick();
        end
        clear_req = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic test_wide();
        int cnt;
        write_enable_w = 1'b1; write_address_w = 4'd7; write_data_w = 64'hA5A5_0000_0000_5A5A;
        for (int p = 0; p < 4; p++) read_address_w[p] = 4'd7;
        #1;
        n_checks++;
        if (rd_w !== {4{64'hA5A5_0000_0000_5A5A}}) begin
            n_fail++;
            $display("FAIL wide_bypass_all_ports: got %h expected 4x a5a500000000 5a5a", rd_w);
        end
        tick();
        write_enable_w = 1'b0;
        #1;
        n_checks++;
        if (rd_w !== {4{64'hA5A5_0000_0000_5A5A}}) begin
            n_fail++;
            $display("FAIL wide_stored_all_ports: got %h expected 4x a5a500000000 5a5a", rd_w);
        end
        for (int i = 0; i < 200; i++) begin
            write_enable_w = $urandom_range(0, 1);
            write_address_w = AWW'($urandom);
            write_data_w = {$urandom, $urandom};
            for (int p = 0; p < 4; p++) read_address_w[p] = AWW'($urandom);
            #1;
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if (rd_w[p] !== exp_rd_w(read_address_w[p])) begin
                    n_fail++;
                    $display("FAIL wide_random cycle %0d port %0d: got %h expected %h", i, p, rd_w[p],
                             exp_rd_w(read_address_w[p]));
                end
            end
            tick();
        end
        write_enable_w = 1'b0;
        clear_req_w = 1'b1;
        tick();
        clear_req_w = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && busy_w; i++) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 15) begin
            n_fail++;
            $display("FAIL wide_sweep_len: got %0d expected 15", cnt);
        end
        for (int p = 0; p < 4; p++) read_address_w[p] = 4'd7;
        #1;
        n_checks++;
        if (rd_w !== '0) begin
            n_fail++;
            $display("FAIL wide_after_clear: got %h expected 0", rd_w);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_random();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
